qosc_freq_meter: RTL and testbench
==================================

// Module: qosc_freq_meter
// PURPOSE
//   Gated frequency counter directly downstream of the ring/quadrature oscillator core in tt_um_qosc.
//   Takes one asynchronous oscillator tap and synchronises it into clk.
//   Counts its rising edges over a fixed window of 2**GATE_LOG2 clk cycles.
//   Latches the count for byte-wise readout on uo_out, with single-shot and continuous modes.
// PARAMETERS
//   GATE_LOG2  10  gate window length = 2**GATE_LOG2 clk cycles (range 4..20)
//   CNT_W      16  edge counter / result width; multiple of 8, 8..32
// PORTS
//   clk          in   1            system clock; all state on rising edge
//   rst          in   1            asynchronous, active-high reset
//   ena          in   1            design enable; low aborts any measurement
//   osc_in       in   1            oscillator tap, asynchronous to clk
//   start        in   1            level-sampled; starts a measurement when idle
//   cont         in   1            1 = re-arm automatically after each result
//   byte_sel     in   max(1,$clog2(CNT_W/8))  result byte index, 0 = LSB
//   result_byte  out  8            result[8*byte_sel +: 8]
//   busy         out  1            measurement window in progress
//   done         out  1            one-cycle pulse when result updates
//   ovf          out  1            latched saturation flag for current result
// BEHAVIOUR
//   Reset (async assert, sync release): FSM=IDLE; all counters, result, ovf=0; busy=0, done=0; result_byte=0.
//   Input path: osc_in -> 2-FF synchroniser -> delay FF; edge = s2 & ~s3.
//     osc_in rise to edge pulse is 3 clk cycles; osc_in pulses narrower than ~1 clk may be missed (documented, not an error).
//   FSM states: IDLE, COUNT, LATCH.
//   IDLE: busy=0. If start & ena: go to COUNT; gate_cnt=0, edge_cnt=0, ovf_run=0.
//   COUNT: busy=1.
//     - gate_cnt increments every cycle (GATE_LOG2 bits).
//     - On edge, edge_cnt increments; at all-ones it holds and sets ovf_run.
//     - When gate_cnt == 2**GATE_LOG2-1, go to LATCH. An edge in that final cycle is counted.
//     - Exactly 2**GATE_LOG2 cycles are sampled.
//   LATCH (1 cycle): busy=1.
//     - result <= edge_cnt (including this cycle's final increment); ovf <= ovf_run; done=1 on the next cycle.
//     - If cont & ena: return to COUNT with counters cleared, so the gap is 1 cycle per window. Else go to IDLE.
//   done: registered, high exactly one cycle, the cycle after LATCH; result/ovf valid on that same cycle.
//   ena=0 in COUNT or LATCH: go to IDLE next cycle, no done, result and ovf unchanged.
//   start while busy: ignored. start held high in IDLE with cont=0: back-to-back single shots (behaves like cont).
//   cont cleared mid-window: current window completes, then IDLE.
//   byte_sel: combinational mux of the registered result.
//     - Out-of-range index (CNT_W=24 with sel=3) returns 8'h00.
//     - Changing byte_sel mid-window is legal; result only changes on LATCH.
//   rst mid-window: immediate clear; no partial result is ever exposed.
//   Max countable rate is clk/2 (edge needs s2 low for >=1 cycle). Saturation needs CNT_W < GATE_LOG2.
// TESTING (clk 10 ns; osc_in asynchronous unless stated)
//   1. Reset check: rst high, random osc_in -> busy=0, done=0, ovf=0, result_byte=00 for both byte_sel.
//   2. Single shot, osc period 40 ns, GATE_LOG2=10, pulse start:
//      -> busy for 1025 cycles, one done pulse, result 256 +/-1 (bytes 00/01), ovf=0, FSM back to IDLE.
//   3. Continuous, osc period 100 ns, cont=1:
//      -> done every 1025 cycles, each result 102 or 103.
//      -> clearing cont mid-window yields exactly one more done.
//   4. Overflow, CNT_W=8, GATE_LOG2=10, osc period 20 ns:
//      -> result 0xFF, ovf=1. A following 1 us-period window gives result 10 +/-1, ovf=0.
//   5. Abort: drop ena at cycle 500 of a window
//      -> busy falls next cycle, no done, previous result/ovf unchanged.
//      -> start ignored while ena=0.
//   6. Async rst asserted mid-window at an arbitrary ns offset -> outputs clear without a clk edge.
//      -> A new start after release gives a full, correct window.

Source files
------------

// File: rtl/qosc_freq_meter.sv
// Gated frequency counter for an asynchronous oscillator tap: counts rising edges over
// 2**GATE_LOG2 clk cycles and latches the count for byte-wise readout.
module qosc_freq_meter #(
  parameter int GATE_LOG2 = 10,
  parameter int CNT_W     = 16,
  localparam int NBYTES   = CNT_W / 8,
  localparam int SEL_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             osc_in,
  input  logic             start,
  input  logic             cont,
  input  logic [SEL_W-1:0] byte_sel,
  output logic [7:0]       result_byte,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_s1, r_s2, r_s3;
  logic                   w_edge;
  logic [GATE_LOG2-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic [CNT_W-1:0]       r_result;
  logic                   r_ovf_run;
  logic                   r_ovf;
  logic                   r_done;
  logic                   w_clear;
  logic                   w_count;
  logic                   w_latch;
  logic [7:0]             w_byte;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0..p2: two-flop synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= osc_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_count     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && ena) begin
          w_state_nxt = COUNT;
          w_clear     = 1'b1;
        end
      end
      COUNT: begin
        if (!ena) begin
          w_state_nxt = IDLE;
        end else begin
          w_count = 1'b1;
          if (&r_gate_cnt) w_state_nxt = LATCH;
        end
      end
      LATCH: begin
        if (!ena) begin
          w_state_nxt = IDLE;
        end else begin
          w_latch = 1'b1;
          if (cont) begin
            // Re-arm straight into COUNT so windows are separated by one cycle.
            w_state_nxt = COUNT;
            w_clear     = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p3: gate/edge counters and the latched result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_run  <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_latch;
      if (w_clear) begin
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_ovf_run  <= 1'b0;
      end else if (w_count) begin
        r_gate_cnt <= r_gate_cnt + GATE_LOG2'(1);
        if (w_edge) begin
          if (&r_edge_cnt) r_ovf_run <= 1'b1;
          r_edge_cnt <= sat_inc(r_edge_cnt);
        end
      end
      if (w_latch) begin
        r_result <= r_edge_cnt;
        r_ovf    <= r_ovf_run;
      end
    end
  end

  // Indices beyond the last result byte read as zero.
  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (int'(byte_sel) == i) w_byte = r_result[8*i +: 8];
    end
  end

  assign result_byte = w_byte;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_qosc_freq_meter.sv
// Directed bench for qosc_freq_meter: a 16-bit and an 8-bit (saturating) instance share
// all inputs; 1 time unit = 0.1 ns, clk period 100 units.
module tb_qosc_freq_meter;

  logic       clk = 1'b0;
  logic       rst, ena, osc_in, start, cont;
  logic [0:0] byte_sel;
  logic [7:0] rb16, rb8;
  logic       busy16, done16, ovf16, busy8, done8, ovf8;

  int n_vec = 0;
  int n_err = 0;
  int half_u = 0;
  int ph = 0;

  typedef struct {
    int half_u;
    int lo16;
    int hi16;
    int lo8;
    int hi8;
    int ovf8;
  } vec_t;

  vec_t vecs[7];

  always #50 clk = ~clk;

  qosc_freq_meter #(.GATE_LOG2(10), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_in), .start(start), .cont(cont),
    .byte_sel(byte_sel), .result_byte(rb16), .busy(busy16), .done(done16), .ovf(ovf16)
  );

  qosc_freq_meter #(.GATE_LOG2(10), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_in), .start(start), .cont(cont),
    .byte_sel(byte_sel), .result_byte(rb8), .busy(busy8), .done(done8), .ovf(ovf8)
  );

  // Oscillator: toggles on a 1 ns grid offset by 0.3 ns, never coincident with clk edges.
  initial begin
    osc_in = 1'b0;
    #3;
    forever begin
      #10;
      if (half_u == 0) begin
        osc_in = 1'b0;
        ph = 0;
      end else begin
        ph += 10;
        if (ph >= half_u) begin
          osc_in = ~osc_in;
          ph = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int lo, input int hi);
    n_vec++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic read_all(output int r16, output int r8, output int r8hi);
    byte_sel = 1'b0;
    #1;
    r16 = int'(rb16);
    r8  = int'(rb8);
    byte_sel = 1'b1;
    #1;
    r16 += int'(rb16) << 8;
    r8hi = int'(rb8);
    byte_sel = 1'b0;
  endtask

  // One single-shot window; fixed observation span so nothing can hang.
  task automatic window(input string tag, input int h, input int lo16, input int hi16,
                        input int lo8, input int hi8, input int exp_ovf8);
    int bc16, dc16, bc8, dc8, r16, r8, r8hi;
    half_u = h;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc16 = 0; dc16 = 0; bc8 = 0; dc8 = 0;
    for (int k = 0; k < 1100; k++) begin
      if (busy16) bc16++;
      if (done16) dc16++;
      if (busy8)  bc8++;
      if (done8)  dc8++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, bc16, 1025, 1025);
    chk({tag, " done_pulses"}, dc16, 1, 1);
    chk({tag, " busy8_cycles"}, bc8, 1025, 1025);
    chk({tag, " done8_pulses"}, dc8, 1, 1);
    read_all(r16, r8, r8hi);
    chk({tag, " result16"}, r16, lo16, hi16);
    chk({tag, " ovf16"}, int'(ovf16), 0, 0);
    chk({tag, " result8"}, r8, lo8, hi8);
    chk({tag, " ovf8"}, int'(ovf8), exp_ovf8, exp_ovf8);
    chk({tag, " result8_sel_oob"}, r8hi, 0, 0);
  endtask

  initial begin
    int r16, r8, r8hi, dc, bc;
    int didx[$];

    vecs[0] = '{200,  255, 257, 255, 255, 1};
    vecs[1] = '{500,  102, 103, 102, 103, 0};
    vecs[2] = '{100,  511, 513, 255, 255, 1};
    vecs[3] = '{5000,   9,  11,   9,  11, 0};
    vecs[4] = '{0,      0,   0,   0,   0, 0};
    vecs[5] = '{150,  341, 342, 255, 255, 1};
    vecs[6] = '{2500,  20,  21,  20,  21, 0};

    rst = 1'b1; ena = 1'b1; start = 1'b0; cont = 1'b0; byte_sel = 1'b0;
    half_u = 70;
    repeat (5) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy16", int'(busy16), 0, 0);
    chk("reset done16", int'(done16), 0, 0);
    chk("reset ovf16", int'(ovf16), 0, 0);
    chk("reset busy8", int'(busy8), 0, 0);
    chk("reset ovf8", int'(ovf8), 0, 0);
    read_all(r16, r8, r8hi);
    chk("reset result16", r16, 0, 0);
    chk("reset result8", r8, 0, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      window($sformatf("v%0d", i), vecs[i].half_u, vecs[i].lo16, vecs[i].hi16,
             vecs[i].lo8, vecs[i].hi8, vecs[i].ovf8);

    // Continuous mode: windows every 1025 cycles, cont dropped mid-way through the fourth.
    half_u = 500;
    repeat (20) @(negedge clk);
    cont = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5600; k++) begin
      if (k == 3575) cont = 1'b0;
      if (done16) begin
        didx.push_back(k);
        read_all(r16, r8, r8hi);
        chk($sformatf("cont result16 #%0d", didx.size()), r16, 102, 103);
      end
      @(negedge clk);
    end
    chk("cont done_count", didx.size(), 4, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("cont done_cycle #%0d", i), (i < didx.size()) ? didx[i] : -1,
          1025 * (i + 1), 1025 * (i + 1));
    chk("cont busy_after", int'(busy16), 0, 0);

    // Abort by dropping ena at cycle 500 of a fast window.
    half_u = 100;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    for (int k = 0; k < 2100; k++) begin
      if (k == 499) chk("abort busy_before", int'(busy16), 1, 1);
      if (k == 500) ena = 1'b0;
      if (k == 501) chk("abort busy_next", int'(busy16), 0, 0);
      if (done16 || done8) dc++;
      @(negedge clk);
    end
    chk("abort done_pulses", dc, 0, 0);
    read_all(r16, r8, r8hi);
    chk("abort result16_kept", r16, 102, 103);
    chk("abort result8_kept", r8, 102, 103);
    chk("abort ovf8_kept", int'(ovf8), 0, 0);
    start = 1'b1;
    bc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy16 || busy8) bc++;
    end
    chk("abort start_ignored", bc, 0, 0);
    start = 1'b0;
    @(negedge clk);
    ena = 1'b1;

    // Asynchronous reset in the middle of a window, off the clock edge.
    half_u = 200;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    @(posedge clk);
    #23;
    rst = 1'b1;
    #1;
    chk("arst busy16", int'(busy16), 0, 0);
    chk("arst busy8", int'(busy8), 0, 0);
    chk("arst done16", int'(done16), 0, 0);
    read_all(r16, r8, r8hi);
    chk("arst result16", r16, 0, 0);
    chk("arst result8", r8, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    window("post_rst", 200, 255, 257, 255, 255, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
